// File: rtl/marcador.sv
// Scoreboard: counts obstacle ticks in 4-digit BCD during gameplay, derives a
// difficulty level, keeps a session high score and drives 7-segment patterns.
module marcador #(
  parameter logic [2:0]  EST_MENU     = 3'd0,
  parameter logic [2:0]  EST_JUEGO    = 3'd2,
  parameter int unsigned PUNTOS_NIVEL = 10,
  parameter logic [2:0]  NIVEL_MAX    = 3'd7,
  parameter logic [15:0] META         = 16'h0050
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  presente,
  input  logic [1:0]  W_or_L,
  input  logic        clk_obstaculos,
  output logic [15:0] puntaje_bcd,
  output logic [15:0] record_bcd,
  output logic [2:0]  nivel,
  output logic        meta,
  output logic [27:0] seg_puntaje
);

  localparam logic [3:0] CNT_ULT = 4'(PUNTOS_NIVEL - 1);

  typedef enum logic [1:0] {INACTIVO, CONTANDO, CONGELADO} estado_t;

  estado_t     estado_q;
  logic [15:0] puntaje_q, record_q, puntaje_inc_d;
  logic [2:0]  nivel_q;
  logic [3:0]  cnt_q;
  logic        meta_q, prev_q, primero_q;
  logic        tick, saturado;

  assign tick     = clk_obstaculos & ~prev_q;
  assign saturado = (puntaje_q == 16'h9999);

  always_comb begin
    logic carry;
    carry         = 1'b1;
    puntaje_inc_d = puntaje_q;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (puntaje_q[4*i +: 4] == 4'd9) begin
          puntaje_inc_d[4*i +: 4] = 4'd0;
        end else begin
          puntaje_inc_d[4*i +: 4] = puntaje_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q  <= INACTIVO;
      puntaje_q <= '0;
      record_q  <= '0;
      nivel_q   <= '0;
      cnt_q     <= '0;
      meta_q    <= 1'b0;
      prev_q    <= 1'b0;
      primero_q <= 1'b0;
    end else begin
      prev_q <= clk_obstaculos;
      case (estado_q)
        INACTIVO: begin
          puntaje_q <= '0;
          nivel_q   <= '0;
          cnt_q     <= '0;
          meta_q    <= 1'b0;
          primero_q <= 1'b0;
          if (presente == EST_JUEGO && W_or_L == 2'b00) estado_q <= CONTANDO;
        end
        CONTANDO: begin
          meta_q <= (puntaje_q >= META);
          // Collision beats a coincident tick.
          if (W_or_L != 2'b00 || presente != EST_JUEGO) begin
            estado_q  <= CONGELADO;
            primero_q <= 1'b1;
          end else if (tick && !saturado) begin
            puntaje_q <= puntaje_inc_d;
            if (cnt_q == CNT_ULT) begin
              cnt_q <= '0;
              if (nivel_q != NIVEL_MAX) nivel_q <= nivel_q + 3'd1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        CONGELADO: begin
          meta_q    <= (puntaje_q >= META);
          primero_q <= 1'b0;
          // BCD ordering matches binary ordering, so a plain compare suffices.
          if (primero_q) begin
            if (puntaje_q > record_q) record_q <= puntaje_q;
          end else if (presente == EST_MENU) begin
            estado_q  <= INACTIVO;
            puntaje_q <= '0;
            nivel_q   <= '0;
            cnt_q     <= '0;
            meta_q    <= 1'b0;
          end
        end
        default: estado_q <= INACTIVO;
      endcase
    end
  end

  always_comb begin
    seg_puntaje = '0;
    for (int i = 0; i < 4; i++) begin
      case (puntaje_q[4*i +: 4])
        4'd0:    seg_puntaje[7*i +: 7] = 7'b0111111;
        4'd1:    seg_puntaje[7*i +: 7] = 7'b0000110;
        4'd2:    seg_puntaje[7*i +: 7] = 7'b1011011;
        4'd3:    seg_puntaje[7*i +: 7] = 7'b1001111;
        4'd4:    seg_puntaje[7*i +: 7] = 7'b1100110;
        4'd5:    seg_puntaje[7*i +: 7] = 7'b1101101;
        4'd6:    seg_puntaje[7*i +: 7] = 7'b1111101;
        4'd7:    seg_puntaje[7*i +: 7] = 7'b0000111;
        4'd8:    seg_puntaje[7*i +: 7] = 7'b1111111;
        4'd9:    seg_puntaje[7*i +: 7] = 7'b1101111;
        default: seg_puntaje[7*i +: 7] = 7'b0000000;
      endcase
    end
  end

  assign puntaje_bcd = puntaje_q;
  assign record_bcd  = record_q;
  assign nivel       = nivel_q;
  assign meta        = meta_q;

endmodule

// File: tb/tb_marcador.sv
// Directed bench for marcador: scoring, edge detect, saturation, record and reset.
module tb_marcador;

  localparam logic [2:0] EST_MENU  = 3'd0;
  localparam logic [2:0] EST_JUEGO = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  presente;
  logic [1:0]  W_or_L;
  logic        clk_obstaculos;
  logic [15:0] puntaje_bcd, record_bcd;
  logic [2:0]  nivel;
  logic        meta;
  logic [27:0] seg_puntaje;

  int pass_cnt  = 0;
  int total_cnt = 0;

  marcador dut (
    .clk(clk), .rst_n(rst_n), .presente(presente), .W_or_L(W_or_L),
    .clk_obstaculos(clk_obstaculos), .puntaje_bcd(puntaje_bcd),
    .record_bcd(record_bcd), .nivel(nivel), .meta(meta),
    .seg_puntaje(seg_puntaje)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      clk_obstaculos = 1'b1;
      step();
      clk_obstaculos = 1'b0;
      step();
    end
  endtask

  task automatic end_game();
    W_or_L = 2'b01;
    step();
    step();
    W_or_L   = 2'b00;
    presente = EST_MENU;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; presente = EST_MENU; W_or_L = 2'b00; clk_obstaculos = 1'b0;
    step(); step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0000 || record_bcd !== 16'h0000 || nivel !== 3'd0 || meta !== 1'b0)
      $display("FAIL reset_outputs: puntaje=%h record=%h nivel=%0d meta=%b, want 0000 0000 0 0",
               puntaje_bcd, record_bcd, nivel, meta);
    else pass_cnt++;
    total_cnt++;
    if (seg_puntaje !== {4{7'b0111111}})
      $display("FAIL reset_seg: got %h want %h", seg_puntaje, {4{7'b0111111}});
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    presente = EST_JUEGO;
    step();
    ticks(12);
    total_cnt++;
    if (puntaje_bcd !== 16'h0012) $display("FAIL basic_score: got %h want 0012", puntaje_bcd);
    else pass_cnt++;
    total_cnt++;
    if (nivel !== 3'd1) $display("FAIL basic_nivel: got %0d want 1", nivel);
    else pass_cnt++;
    total_cnt++;
    if (seg_puntaje[13:0] !== {7'b0000110, 7'b1011011})
      $display("FAIL basic_seg: got %b want %b", seg_puntaje[13:0], {7'b0000110, 7'b1011011});
    else pass_cnt++;
  endtask

  task automatic test_held_strobe();
    clk_obstaculos = 1'b1;
    for (int i = 0; i < 20; i++) step();
    clk_obstaculos = 1'b0;
    step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0013) $display("FAIL held_strobe: got %h want 0013", puntaje_bcd);
    else pass_cnt++;
    end_game();
    total_cnt++;
    if (record_bcd !== 16'h0013 || puntaje_bcd !== 16'h0000)
      $display("FAIL first_record: record=%h score=%h want 0013 0000", record_bcd, puntaje_bcd);
    else pass_cnt++;
  endtask

  task automatic test_high_at_entry();
    clk_obstaculos = 1'b1;
    step();
    presente = EST_JUEGO;
    step(); step(); step();
    clk_obstaculos = 1'b0;
    step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0000) $display("FAIL high_at_entry: got %h want 0000", puntaje_bcd);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    ticks(49);
    total_cnt++;
    if (puntaje_bcd !== 16'h0049 || meta !== 1'b0)
      $display("FAIL pre_collision: score=%h meta=%b want 0049 0", puntaje_bcd, meta);
    else pass_cnt++;
    clk_obstaculos = 1'b1; W_or_L = 2'b01;
    step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0049) $display("FAIL collision_wins: got %h want 0049", puntaje_bcd);
    else pass_cnt++;
    clk_obstaculos = 1'b0;
    step();
    total_cnt++;
    if (record_bcd !== 16'h0049 || meta !== 1'b0)
      $display("FAIL collision_record: record=%h meta=%b want 0049 0", record_bcd, meta);
    else pass_cnt++;
    W_or_L = 2'b00; presente = EST_MENU;
    step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0000 || record_bcd !== 16'h0049)
      $display("FAIL back_to_menu: score=%h record=%h want 0000 0049", puntaje_bcd, record_bcd);
    else pass_cnt++;
  endtask

  task automatic test_record_keep();
    presente = EST_JUEGO;
    step();
    ticks(30);
    total_cnt++;
    if (puntaje_bcd !== 16'h0030) $display("FAIL second_game_score: got %h want 0030", puntaje_bcd);
    else pass_cnt++;
    end_game();
    total_cnt++;
    if (record_bcd !== 16'h0049) $display("FAIL record_kept: got %h want 0049", record_bcd);
    else pass_cnt++;
  endtask

  task automatic test_meta();
    presente = EST_JUEGO;
    step();
    ticks(49);
    clk_obstaculos = 1'b1;
    step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0050 || meta !== 1'b0)
      $display("FAIL meta_lag: score=%h meta=%b want 0050 0", puntaje_bcd, meta);
    else pass_cnt++;
    clk_obstaculos = 1'b0;
    step();
    total_cnt++;
    if (meta !== 1'b1) $display("FAIL meta_set: got %b want 1", meta);
    else pass_cnt++;
    W_or_L = 2'b01;
    step(); step();
    total_cnt++;
    if (record_bcd !== 16'h0050 || meta !== 1'b1)
      $display("FAIL meta_record: record=%h meta=%b want 0050 1", record_bcd, meta);
    else pass_cnt++;
    W_or_L = 2'b00; presente = EST_MENU;
    step();
    total_cnt++;
    if (meta !== 1'b0 || puntaje_bcd !== 16'h0000)
      $display("FAIL meta_clear: meta=%b score=%h want 0 0000", meta, puntaje_bcd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    presente = EST_JUEGO;
    step();
    ticks(23);
    total_cnt++;
    if (puntaje_bcd !== 16'h0023 || nivel !== 3'd2)
      $display("FAIL mid_score: score=%h nivel=%0d want 0023 2", puntaje_bcd, nivel);
    else pass_cnt++;
    rst_n = 1'b0; presente = EST_MENU;
    step();
    total_cnt++;
    if (puntaje_bcd !== 16'h0000 || record_bcd !== 16'h0000 || nivel !== 3'd0 || meta !== 1'b0)
      $display("FAIL mid_reset: score=%h record=%h nivel=%0d meta=%b want all 0",
               puntaje_bcd, record_bcd, nivel, meta);
    else pass_cnt++;
    rst_n = 1'b1;
    ticks(2);
    total_cnt++;
    if (puntaje_bcd !== 16'h0000) $display("FAIL idle_after_reset: got %h want 0000", puntaje_bcd);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    presente = EST_JUEGO;
    step();
    ticks(999);
    total_cnt++;
    if (puntaje_bcd !== 16'h0999) $display("FAIL score_0999: got %h want 0999", puntaje_bcd);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (puntaje_bcd !== 16'h1000) $display("FAIL carry_1000: got %h want 1000", puntaje_bcd);
    else pass_cnt++;
    ticks(8999);
    total_cnt++;
    if (puntaje_bcd !== 16'h9999 || nivel !== 3'd7)
      $display("FAIL reach_9999: score=%h nivel=%0d want 9999 7", puntaje_bcd, nivel);
    else pass_cnt++;
    ticks(3);
    total_cnt++;
    if (puntaje_bcd !== 16'h9999 || nivel !== 3'd7)
      $display("FAIL saturate: score=%h nivel=%0d want 9999 7", puntaje_bcd, nivel);
    else pass_cnt++;
    total_cnt++;
    if (seg_puntaje !== {4{7'b1101111}})
      $display("FAIL seg_9999: got %h want %h", seg_puntaje, {4{7'b1101111}});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_strobe();
    test_high_at_entry();
    test_collision();
    test_record_keep();
    test_meta();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/marcador.md
Name: marcador

Overview:
Scoreboard stage downstream of the collision checker and obstacle generator. It counts obstacles survived during gameplay in 4-digit BCD and derives a difficulty level. It also keeps a session high score and emits 7-segment patterns for the display multiplexer. It consumes presente, W_or_L and clk_obstaculos.

Parameters:
EST_MENU, 3'd0, presente code for the menu state.
EST_JUEGO, 3'd2, presente code for active gameplay.
PUNTOS_NIVEL, 10, ticks per level increment (range 2..15).
NIVEL_MAX, 7, saturation value of nivel.
META, 16'h0050, target score in BCD.

Ports:
clk  input  1  system clock.
rst_n  input  1  synchronous reset, active-low.
presente  input  3  game FSM state code.
W_or_L  input  2  collision result: 00 = running, any other value = game over.
clk_obstaculos  input  1  obstacle step strobe/slow clock. Sampled in the clk domain.
puntaje_bcd  output  16  current score, 4 BCD digits, digit 3 in [15:12].
record_bcd  output  16  highest score since reset, BCD.
nivel  output  3  difficulty level, 0..NIVEL_MAX.
meta  output  1  high while the current score >= META.
seg_puntaje  output  28  7-segment patterns for puntaje_bcd. Digit 3 in [27:21]. Each digit is gfedcba, active-high.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous, active-low (rst_n). All registers update on the rising edge of clk.
- Reset values: puntaje_bcd=0, record_bcd=0, nivel=0, meta=0, internal level counter=0, edge register=0, state=INACTIVO.
- seg_puntaje is a combinational decode of puntaje_bcd. After reset it shows "0000" (each digit 7'b0111111).
- Edge detect: prev <= clk_obstaculos every cycle, regardless of state. tick = clk_obstaculos & ~prev.
  - A strobe held high for N cycles gives exactly one tick.
  - A strobe already high on entry to CONTANDO is not counted.
- FSM states: INACTIVO, CONTANDO, CONGELADO.
  - INACTIVO:
    - Holds puntaje_bcd=0, nivel=0, level counter=0, meta=0.
    - -> CONTANDO when presente==EST_JUEGO && W_or_L==00.
    - A tick in the transition cycle is ignored.
  - CONTANDO, priority order:
    1. W_or_L!=00 -> CONGELADO. A tick in the same cycle is discarded (collision wins).
    2. presente!=EST_JUEGO -> CONGELADO.
    3. On tick:
       - puntaje_bcd increments in BCD with a carry chain (0009->0010, 0999->1000).
       - 9999 saturates; further ticks leave score, nivel and level counter unchanged.
       - Level counter increments. When it equals PUNTOS_NIVEL-1 it wraps to 0 and nivel increments, saturating at NIVEL_MAX.
  - CONGELADO:
    - Score and nivel hold.
    - In the first cycle after entry: record_bcd <= puntaje_bcd if puntaje_bcd > record_bcd (BCD magnitude compare).
    - -> INACTIVO when presente==EST_MENU. Evaluated from the second cycle in CONGELADO, so the record update is never skipped.
- Latency:
  - tick -> puntaje_bcd updated 1 cycle after the clk edge that samples the strobe rising.
  - meta is registered. It follows the score one cycle later.
- meta: set when puntaje_bcd >= META in CONTANDO or CONGELADO. Cleared in INACTIVO.
- record_bcd survives game restarts. Only rst_n clears it.
- Reset mid-game: rst_n low in any state clears everything, including record_bcd, on that edge.

Test Plan:
- rst_n low 2 cycles, then presente=EST_JUEGO, W_or_L=00, 12 single-cycle strobes -> puntaje_bcd=16'h0012, nivel=1, seg_puntaje digit0 = 7'b1011011 ("2").
- Strobe held high 20 cycles during CONTANDO -> exactly +1 score. Strobe already high at entry -> score stays 0000.
- Preload score 0999 via 999 ticks, one more tick -> 16'h1000. Drive to 9999 plus 3 extra ticks -> stays 9999, nivel=NIVEL_MAX=7.
- Score 0049, tick and W_or_L=01 in the same cycle -> state CONGELADO, score 0049, meta=0, record_bcd=0049 two cycles later. Then presente=EST_MENU -> score 0000, record kept.
- Second game scoring 0030 after record 0049 -> record_bcd stays 0049. A game reaching 0050 -> meta=1 one cycle after the score, record becomes 0050 after the game ends.
- rst_n low for 1 cycle mid-CONTANDO with score 0023 -> next cycle all outputs 0, state INACTIVO, record_bcd=0.
